rst_table: RTL and testbench

Register Status Table for the Tomasulo/ROB out-of-order MIPS core. It holds, per architectural register (32 entries), the ROB tag of the youngest in-flight producer plus a valid (busy) bit. Dispatch reads two source registers (Rs, Rt) to get rename tags and allocates a tag for the destination. Commit clears entries whose tag retires. Flush invalidates everything.

---
 rtl/rst_table.sv | 89 ++++++++
 tb/tb_rst_table.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_table.sv
// rst_table: register status table for the out-of-order core.
// Each of the NREG architectural registers holds the ROB tag of its youngest
// in-flight producer plus a busy bit. Dispatch reads two sources (Rs, Rt) and
// allocates a tag for the destination; commit clears busy bits whose tag
// retires; flush clears every busy bit.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   Rsaddr_rst/Rtaddr_rst : source register addresses
//   Rstag_rst/Rttag_rst   : stored tag for each source (combinational read)
//   Rsvalid_rst/Rtvalid_rst : busy bit for each source (combinational read)
//   RB_tag_rst, RB_valid_rst : committing ROB tag and its strobe
//   Wdata_rst, Waddr_rst, Wen_rst : destination tag allocation
//   Wen0_rst            : per-entry busy-bit clear mask
//   Wen1_rst            : one-hot decoded allocate enable (combinational)
//   flush               : level-sensitive clear of all busy bits
module rst_table #(
  parameter int unsigned NREG = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        Rsaddr_rst,
  output logic [TAGW-1:0]   Rstag_rst,
  output logic              Rsvalid_rst,
  input  logic [4:0]        Rtaddr_rst,
  output logic [TAGW-1:0]   Rttag_rst,
  output logic              Rtvalid_rst,
  input  logic [TAGW-1:0]   RB_tag_rst,
  input  logic              RB_valid_rst,
  input  logic [TAGW-1:0]   Wdata_rst,
  input  logic [4:0]        Waddr_rst,
  input  logic              Wen_rst,
  input  logic [NREG-1:0]   Wen0_rst,
  output logic [NREG-1:0]   Wen1_rst,
  input  logic              flush
);

  logic [TAGW-1:0] tag_q [NREG];
  logic [TAGW-1:0] tag_d [NREG];
  logic [NREG-1:0] valid_q;
  logic [NREG-1:0] valid_d;
  logic [NREG-1:0] wen1;

  // One-hot allocate decode.
  always_comb begin
    wen1 = '0;
    if (Wen_rst) wen1[Waddr_rst] = 1'b1;
  end

  assign Wen1_rst = wen1;

  // Reads come straight from registered state: no same-cycle bypass.
  assign Rstag_rst   = tag_q[Rsaddr_rst];
  assign Rsvalid_rst = valid_q[Rsaddr_rst];
  assign Rttag_rst   = tag_q[Rtaddr_rst];
  assign Rtvalid_rst = valid_q[Rtaddr_rst];

  // Per-entry update: flush > allocate > mask clear > commit match > hold.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    for (int i = 0; i < int'(NREG); i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (wen1[i]) begin
        tag_d[i]   = Wdata_rst;
        valid_d[i] = 1'b1;
      end else if (Wen0_rst[i]) begin
        valid_d[i] = 1'b0;
      end else if (RB_valid_rst && valid_q[i] && (tag_q[i] == RB_tag_rst)) begin
        // Commit retires the busy bit but leaves the tag in place.
        valid_d[i] = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) tag_q[i] <= '0;
      valid_q <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_rst_table.sv
module tb_rst_table;

  logic        clock;
  logic        reset;
  logic [4:0]  Rsaddr_rst;
  logic [4:0]  Rstag_rst;
  logic        Rsvalid_rst;
  logic [4:0]  Rtaddr_rst;
  logic [4:0]  Rttag_rst;
  logic        Rtvalid_rst;
  logic [4:0]  RB_tag_rst;
  logic        RB_valid_rst;
  logic [4:0]  Wdata_rst;
  logic [4:0]  Waddr_rst;
  logic        Wen_rst;
  logic [31:0] Wen0_rst;
  logic [31:0] Wen1_rst;
  logic        flush;

  int total;
  int bad;

  // Hand-maintained expected table contents.
  logic [4:0] exp_tag [32];
  logic       exp_val [32];

  rst_table dut (
    .clock        (clock),
    .reset        (reset),
    .Rsaddr_rst   (Rsaddr_rst),
    .Rstag_rst    (Rstag_rst),
    .Rsvalid_rst  (Rsvalid_rst),
    .Rtaddr_rst   (Rtaddr_rst),
    .Rttag_rst    (Rttag_rst),
    .Rtvalid_rst  (Rtvalid_rst),
    .RB_tag_rst   (RB_tag_rst),
    .RB_valid_rst (RB_valid_rst),
    .Wdata_rst    (Wdata_rst),
    .Waddr_rst    (Waddr_rst),
    .Wen_rst      (Wen_rst),
    .Wen0_rst     (Wen0_rst),
    .Wen1_rst     (Wen1_rst),
    .flush        (flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_tag[i] = 5'd0;
      exp_val[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      Rsaddr_rst = 5'(i);
      Rtaddr_rst = 5'(31 - i);
      #1;
      total++;
      if (Rstag_rst !== 5'd0 || Rsvalid_rst !== 1'b0) begin
        bad++;
        $display("FAIL reset_rs addr=%0d got tag=%0d v=%b want tag=0 v=0", i, Rstag_rst, Rsvalid_rst);
      end
      total++;
      if (Rttag_rst !== 5'd0 || Rtvalid_rst !== 1'b0) begin
        bad++;
        $display("FAIL reset_rt addr=%0d got tag=%0d v=%b want tag=0 v=0", 31 - i, Rttag_rst, Rtvalid_rst);
      end
    end
    total++;
    if (Wen1_rst !== 32'h0) begin
      bad++;
      $display("FAIL reset_wen1 got=%h want=00000000", Wen1_rst);
    end
  endtask

  task automatic test_alloc_all();
    for (int i = 0; i < 32; i++) begin
      Waddr_rst  = 5'(i);
      Wdata_rst  = 5'(i);
      Wen_rst    = 1'b1;
      Rsaddr_rst = 5'(i);
      #1;
      total++;
      if (Wen1_rst !== (32'd1 << i)) begin
        bad++;
        $display("FAIL alloc_wen1 i=%0d got=%h want=%h", i, Wen1_rst, 32'd1 << i);
      end
      // Allocation must not be visible before its edge.
      total++;
      if (Rsvalid_rst !== 1'b0) begin
        bad++;
        $display("FAIL alloc_bypass i=%0d got v=%b want v=0", i, Rsvalid_rst);
      end
      tick();
      exp_tag[i] = 5'(i);
      exp_val[i] = 1'b1;
    end
    Wen_rst = 1'b0;
    #1;
    total++;
    if (Wen1_rst !== 32'h0) begin
      bad++;
      $display("FAIL alloc_wen1_idle got=%h want=00000000", Wen1_rst);
    end
    // Rs sweep, Rt sweep, then both together on different addresses.
    for (int i = 0; i < 32; i++) begin
      Rsaddr_rst = 5'(i);
      #1;
      total++;
      if (Rstag_rst !== 5'(i) || Rsvalid_rst !== 1'b1) begin
        bad++;
        $display("FAIL alloc_rs addr=%0d got tag=%0d v=%b want tag=%0d v=1", i, Rstag_rst, Rsvalid_rst, i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      Rtaddr_rst = 5'(i);
      #1;
      total++;
      if (Rttag_rst !== 5'(i) || Rtvalid_rst !== 1'b1) begin
        bad++;
        $display("FAIL alloc_rt addr=%0d got tag=%0d v=%b want tag=%0d v=1", i, Rttag_rst, Rtvalid_rst, i);
      end
    end
    for (int i = 0; i < 32; i++) begin
      Rsaddr_rst = 5'(i);
      Rtaddr_rst = 5'(31 - i);
      #1;
      total++;
      if (Rstag_rst !== 5'(i) || Rttag_rst !== 5'(31 - i) ||
          Rsvalid_rst !== 1'b1 || Rtvalid_rst !== 1'b1) begin
        bad++;
        $display("FAIL alloc_both i=%0d got rs=%0d/%b rt=%0d/%b want rs=%0d/1 rt=%0d/1",
                 i, Rstag_rst, Rsvalid_rst, Rttag_rst, Rtvalid_rst, i, 31 - i);
      end
    end
  endtask

  task automatic test_commit();
    RB_tag_rst   = 5'd2;
    RB_valid_rst = 1'b1;
    tick();
    RB_valid_rst = 1'b0;
    exp_val[2] = 1'b0;
    Rsaddr_rst = 5'd2;
    Rtaddr_rst = 5'd1;
    #1;
    total++;
    if (Rstag_rst !== 5'd2 || Rsvalid_rst !== 1'b0) begin
      bad++;
      $display("FAIL commit_e2 got tag=%0d v=%b want tag=2 v=0", Rstag_rst, Rsvalid_rst);
    end
    total++;
    if (Rttag_rst !== 5'd1 || Rtvalid_rst !== 1'b1) begin
      bad++;
      $display("FAIL commit_e1 got tag=%0d v=%b want tag=1 v=1", Rttag_rst, Rtvalid_rst);
    end
    Rtaddr_rst = 5'd3;
    #1;
    total++;
    if (Rttag_rst !== 5'd3 || Rtvalid_rst !== 1'b1) begin
      bad++;
      $display("FAIL commit_e3 got tag=%0d v=%b want tag=3 v=1", Rttag_rst, Rtvalid_rst);
    end
  endtask

  task automatic test_collision();
    // Allocate wins over a same-edge commit of the old tag.
    Wen_rst      = 1'b1;
    Waddr_rst    = 5'd5;
    Wdata_rst    = 5'd9;
    RB_tag_rst   = 5'd5;
    RB_valid_rst = 1'b1;
    tick();
    Wen_rst      = 1'b0;
    RB_valid_rst = 1'b0;
    exp_tag[5] = 5'd9;
    Rsaddr_rst = 5'd5;
    #1;
    total++;
    if (Rstag_rst !== 5'd9 || Rsvalid_rst !== 1'b1) begin
      bad++;
      $display("FAIL collide_e5 got tag=%0d v=%b want tag=9 v=1", Rstag_rst, Rsvalid_rst);
    end
    // A later commit of the stale tag leaves the entry busy.
    RB_tag_rst   = 5'd5;
    RB_valid_rst = 1'b1;
    tick();
    RB_valid_rst = 1'b0;
    #1;
    total++;
    if (Rstag_rst !== 5'd9 || Rsvalid_rst !== 1'b1) begin
      bad++;
      $display("FAIL stale_commit_e5 got tag=%0d v=%b want tag=9 v=1", Rstag_rst, Rsvalid_rst);
    end
    // Commit of tag 9 clears every matching entry (5 and 9).
    RB_tag_rst   = 5'd9;
    RB_valid_rst = 1'b1;
    tick();
    RB_valid_rst = 1'b0;
    exp_val[5] = 1'b0;
    exp_val[9] = 1'b0;
    Rtaddr_rst = 5'd9;
    #1;
    total++;
    if (Rstag_rst !== 5'd9 || Rsvalid_rst !== 1'b0 ||
        Rttag_rst !== 5'd9 || Rtvalid_rst !== 1'b0) begin
      bad++;
      $display("FAIL multi_commit got e5=%0d/%b e9=%0d/%b want 9/0 9/0",
               Rstag_rst, Rsvalid_rst, Rttag_rst, Rtvalid_rst);
    end
  endtask

  task automatic test_flush();
    flush     = 1'b1;
    Wen_rst   = 1'b1;
    Waddr_rst = 5'd0;
    Wdata_rst = 5'd17;
    tick();
    Wen_rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_val[i] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rsaddr_rst = 5'(i);
      #1;
      total++;
      if (Rstag_rst !== exp_tag[i] || Rsvalid_rst !== 1'b0) begin
        bad++;
        $display("FAIL flush addr=%0d got tag=%0d v=%b want tag=%0d v=0", i, Rstag_rst, Rsvalid_rst, exp_tag[i]);
      end
    end
    // Still held: an allocate on this edge must also be dropped.
    Wen_rst   = 1'b1;
    Waddr_rst = 5'd12;
    Wdata_rst = 5'd20;
    tick();
    Wen_rst = 1'b0;
    Rtaddr_rst = 5'd12;
    #1;
    total++;
    if (Rttag_rst !== 5'd12 || Rtvalid_rst !== 1'b0) begin
      bad++;
      $display("FAIL flush_held got tag=%0d v=%b want tag=12 v=0", Rttag_rst, Rtvalid_rst);
    end
    flush = 1'b0;
  endtask

  task automatic test_wen0();
    // Refill every entry with tag 31-i.
    for (int i = 0; i < 32; i++) begin
      Wen_rst   = 1'b1;
      Waddr_rst = 5'(i);
      Wdata_rst = 5'(31 - i);
      tick();
      exp_tag[i] = 5'(31 - i);
      exp_val[i] = 1'b1;
    end
    // Mask bits 4..7 and 10; entry 10 is allocated on the same edge and stays busy.
    Wen0_rst  = 32'h0000_04F0;
    Wen_rst   = 1'b1;
    Waddr_rst = 5'd10;
    Wdata_rst = 5'd7;
    tick();
    Wen0_rst = 32'h0;
    Wen_rst  = 1'b0;
    for (int i = 4; i < 8; i++) exp_val[i] = 1'b0;
    exp_tag[10] = 5'd7;
    for (int i = 0; i < 32; i++) begin
      Rsaddr_rst = 5'(i);
      Rtaddr_rst = 5'(i);
      #1;
      total++;
      if (Rstag_rst !== exp_tag[i] || Rsvalid_rst !== exp_val[i] ||
          Rttag_rst !== exp_tag[i] || Rtvalid_rst !== exp_val[i]) begin
        bad++;
        $display("FAIL wen0 addr=%0d got rs=%0d/%b rt=%0d/%b want %0d/%b",
                 i, Rstag_rst, Rsvalid_rst, Rttag_rst, Rtvalid_rst, exp_tag[i], exp_val[i]);
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    Rsaddr_rst   = 5'd0;
    Rtaddr_rst   = 5'd0;
    RB_tag_rst   = 5'd0;
    RB_valid_rst = 1'b0;
    Wdata_rst    = 5'd0;
    Waddr_rst    = 5'd0;
    Wen_rst      = 1'b0;
    Wen0_rst     = 32'h0;
    flush        = 1'b0;
    test_reset();
    test_alloc_all();
    test_commit();
    test_collision();
    test_flush();
    test_wen0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
